// File: rtl/mul_div_unit_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
// The master issues operations and the slave (the unit itself) returns results.
interface mul_div_unit_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              div_zero;
  logic              ovf;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_zero, ovf
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_zero, ovf
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide engine: shift-add MUL, restoring DIV,
// sign handled as magnitude + final correction, start/busy/done handshake.
module mul_div_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int ACC_W = 2 * DATA_W + 1;
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_min_neg1;
  logic [DATA_W-1:0]  r_opnd;
  logic [ACC_W-1:0]   r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic               r_ovf;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;

  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic                w_div0;
  logic                w_min_neg1;
  logic [ACC_W-1:0]    w_shift;
  logic [DATA_W+1:0]   w_trial;
  logic [DATA_W:0]     w_sum;
  logic [ACC_W-1:0]    w_acc_next;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;

  // op[0]=1 selects the unsigned variants; op[1]=1 selects divide.
  assign w_a_neg    = ~bus.op[0] & bus.a[DATA_W-1];
  assign w_b_neg    = ~bus.op[0] & bus.b[DATA_W-1];
  assign w_a_mag    = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag    = w_b_neg ? -bus.b : bus.b;
  assign w_div0     = bus.op[1] & (bus.b == '0);
  assign w_min_neg1 = (bus.op == 2'b10) & (bus.a == MIN_VAL) & (&bus.b);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_shift    = '0;
    w_trial    = '0;
    w_sum      = '0;
    w_acc_next = r_acc;
    if (r_is_div) begin
      w_shift = r_acc << 1;
      w_trial = {1'b0, w_shift[ACC_W-1:DATA_W]} - {2'b00, r_opnd};
      if (!w_trial[DATA_W+1])
        w_acc_next = {w_trial[DATA_W:0], w_shift[DATA_W-1:1], 1'b1};
      else
        w_acc_next = w_shift;
    end else begin
      w_sum      = r_acc[ACC_W-1:DATA_W] + (r_acc[0] ? {1'b0, r_opnd} : '0);
      w_acc_next = {w_sum, r_acc[DATA_W-1:0]} >> 1;
    end
  end

  assign w_prod = r_neg_q ? -w_acc_next[2*DATA_W-1:0] : w_acc_next[2*DATA_W-1:0];
  assign w_quo  = r_neg_q ? -w_acc_next[DATA_W-1:0] : w_acc_next[DATA_W-1:0];
  assign w_rem  = r_neg_r ? -w_acc_next[2*DATA_W-1:DATA_W]
                          : w_acc_next[2*DATA_W-1:DATA_W];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_min_neg1 <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.flush || !bus.start) begin
            r_state <= S_IDLE;
          end else begin
            r_is_div   <= bus.op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_min_neg1 <= w_min_neg1;
            if (w_div0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_hi       <= bus.a;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
              r_ovf      <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_W'(DATA_W);
              r_opnd  <= bus.op[1] ? w_b_mag : w_a_mag;
              r_acc   <= {{(DATA_W+1){1'b0}}, bus.op[1] ? w_a_mag : w_b_mag};
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_div_zero <= 1'b0;
              r_ovf      <= r_is_div & r_min_neg1;
              if (!r_is_div) begin
                {r_hi, r_lo} <= w_prod;
              end else if (r_min_neg1) begin
                r_hi <= '0;
                r_lo <= MIN_VAL;
              end else begin
                r_hi <= w_rem;
                r_lo <= w_quo;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.div_zero = r_div_zero;
  assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at DATA_W = 8, 16 and 32; one unit is
// driven at a time through a shared stimulus/observation mux.
module tb_mul_div_unit;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          cur_w   = 16;
  logic        d_start = 1'b0;
  logic        d_flush = 1'b0;
  logic [1:0]  d_op    = 2'b00;
  logic [31:0] d_a     = '0;
  logic [31:0] d_b     = '0;

  mul_div_unit_if #(.DATA_W(8))  bus8 ();
  mul_div_unit_if #(.DATA_W(16)) bus16 ();
  mul_div_unit_if #(.DATA_W(32)) bus32 ();

  mul_div_unit #(.DATA_W(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));
  mul_div_unit #(.DATA_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  mul_div_unit #(.DATA_W(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));

  assign bus8.start  = d_start && (cur_w == 8);
  assign bus8.flush  = d_flush && (cur_w == 8);
  assign bus8.op     = d_op;
  assign bus8.a      = d_a[7:0];
  assign bus8.b      = d_b[7:0];
  assign bus16.start = d_start && (cur_w == 16);
  assign bus16.flush = d_flush && (cur_w == 16);
  assign bus16.op    = d_op;
  assign bus16.a     = d_a[15:0];
  assign bus16.b     = d_b[15:0];
  assign bus32.start = d_start && (cur_w == 32);
  assign bus32.flush = d_flush && (cur_w == 32);
  assign bus32.op    = d_op;
  assign bus32.a     = d_a;
  assign bus32.b     = d_b;

  logic        s_busy, s_done, s_dz, s_ovf;
  logic [31:0] s_hi, s_lo;

  always_comb begin
    case (cur_w)
      8: begin
        s_busy = bus8.busy;  s_done = bus8.done;
        s_dz   = bus8.div_zero; s_ovf = bus8.ovf;
        s_hi   = {24'd0, bus8.hi}; s_lo = {24'd0, bus8.lo};
      end
      32: begin
        s_busy = bus32.busy; s_done = bus32.done;
        s_dz   = bus32.div_zero; s_ovf = bus32.ovf;
        s_hi   = bus32.hi; s_lo = bus32.lo;
      end
      default: begin
        s_busy = bus16.busy; s_done = bus16.done;
        s_dz   = bus16.div_zero; s_ovf = bus16.ovf;
        s_hi   = {16'd0, bus16.hi}; s_lo = {16'd0, bus16.lo};
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents a one-cycle start pulse.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    d_op    = op;
    d_a     = a;
    d_b     = b;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n_busy, output int n_cyc);
    n_busy = 0;
    n_cyc  = 0;
    while (!s_done && n_cyc < 100) begin
      if (s_busy) n_busy++;
      @(negedge clk);
      n_cyc++;
    end
    check({tag, "_done_seen"}, s_done, 1'b1);
  endtask

  task automatic run_check(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic exp_dz, input logic exp_ovf, input int exp_busy);
    int nb, nc;
    issue(op, a, b);
    wait_done(tag, nb, nc);
    check({tag, "_busy_cycles"}, nb, exp_busy);
    check({tag, "_latency"}, nc, exp_busy);
    check({tag, "_hi"}, s_hi, exp_hi);
    check({tag, "_lo"}, s_lo, exp_lo);
    check({tag, "_div_zero"}, s_dz, exp_dz);
    check({tag, "_ovf"}, s_ovf, exp_ovf);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      if (s_done) seen++;
      @(negedge clk);
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {s_busy, s_done, s_dz, s_ovf, s_hi, s_lo}, '0);
    reset = 1'b1;
    @(negedge clk);

    run_check("mul_s", 2'b00, 32'h0007, 32'hFFFD, 32'hFFFF, 32'hFFEB, 1'b0, 1'b0, 16);
    @(negedge clk);
    check("done_one_cycle", s_done, 1'b0);

    run_check("mulu", 2'b01, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, 1'b0, 1'b0, 16);
    // Issued while the previous result is still in DONE.
    run_check("divu_b2b", 2'b11, 32'd100, 32'd7, 32'h0002, 32'h000E, 1'b0, 1'b0, 16);

    run_check("div_s", 2'b10, 32'hFFF9, 32'h0002, 32'hFFFF, 32'hFFFD, 1'b0, 1'b0, 16);
    run_check("div_ovf", 2'b10, 32'h8000, 32'hFFFF, 32'h0000, 32'h8000, 1'b0, 1'b1, 16);
    run_check("divu_zero", 2'b11, 32'h0064, 32'h0000, 32'h0064, 32'hFFFF, 1'b1, 1'b0, 0);
    run_check("flags_clear", 2'b01, 32'd3, 32'd4, 32'h0000, 32'h000C, 1'b0, 1'b0, 16);

    // A start while busy must not disturb the running 6*7.
    @(negedge clk);
    issue(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    issue(2'b11, 32'd50, 32'd5);
    begin
      int nb, nc;
      wait_done("ign_start", nb, nc);
    end
    check("ign_start_lo", s_lo, 32'd42);
    check("ign_start_hi", s_hi, 32'd0);

    // Flush at busy cycle 5 of a MUL.
    @(negedge clk);
    issue(2'b00, 32'h1234, 32'h5678);
    repeat (4) @(negedge clk);
    d_flush = 1'b1;
    @(negedge clk);
    d_flush = 1'b0;
    check("flush_busy", s_busy, 1'b0);
    count_done("flush_no_done", 25);
    check("flush_hi_kept", s_hi, 32'd0);
    check("flush_lo_kept", s_lo, 32'd42);

    // flush wins over a simultaneous start.
    d_flush = 1'b1;
    issue(2'b01, 32'd3, 32'd5);
    d_flush = 1'b0;
    check("flush_start_busy", s_busy, 1'b0);
    count_done("flush_start_no_done", 25);
    check("flush_start_lo_kept", s_lo, 32'd42);

    // Asynchronous reset mid-run.
    issue(2'b01, 32'hFFFF, 32'hFFFF);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", {s_busy, s_done, s_dz, s_ovf, s_hi, s_lo}, '0);
    @(negedge clk);
    reset = 1'b1;
    count_done("reset_no_done", 3);
    run_check("post_reset", 2'b01, 32'd3, 32'd5, 32'h0000, 32'h000F, 1'b0, 1'b0, 16);

    cur_w = 8;
    @(negedge clk);
    run_check("w8_mul", 2'b00, 32'h07, 32'hFD, 32'hFF, 32'hEB, 1'b0, 1'b0, 8);
    run_check("w8_div", 2'b10, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, 1'b0, 8);

    cur_w = 32;
    @(negedge clk);
    run_check("w32_mul", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 32);
    run_check("w32_div", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit. It is the next-generation execute-stage arithmetic engine of the pipelined datapath and generalises the single-cycle ALU high/low result path to any DATA_W. It produces a full 2*DATA_W product, or a quotient and remainder. It exposes a start/busy/done handshake so the hazard unit can freeze the PC and F/D registers and insert bubbles while it runs. It also accepts a flush from branch/jump squashing.

Parameters:
DATA_W, 16, operand and result-half width in bits (min 4).
CNT_W, $clog2(DATA_W+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request new operation; sampled in IDLE or DONE only
op  input  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU
a  input  DATA_W  multiplicand / dividend
b  input  DATA_W  multiplier / divisor
flush  input  1  abort in-flight operation (squash)
busy  output  1  high while iterating; drives hazard stall
done  output  1  one-cycle pulse: hi/lo/flags valid
hi  output  DATA_W  product upper half / remainder
lo  output  DATA_W  product lower half / quotient
div_zero  output  1  last op was a divide by zero
ovf  output  1  last op was signed DIV of MIN by -1

Behaviour:
- Reset (reset=0, async): state=IDLE. busy, done, hi, lo, div_zero, ovf are all 0. Counter is 0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 and flush=0: latch op, |a|, |b| and sign info. The counter loads DATA_W and the unit goes to RUN.
  - DONE with start=0 goes to IDLE.
  - RUN: one radix-2 step per cycle. Shift-add for MUL; restoring shift-subtract for DIV. The counter decrements; at count 1 the final step completes and the unit goes to DONE.
- Latency: start accepted at edge k. busy=1 for cycles k+1..k+DATA_W. done=1 in cycle k+DATA_W+1. Results and flags update on the edge entering DONE.
- Back-to-back: start during DONE is accepted. done stays 1 only in that cycle, and busy rises next cycle.
- start while busy: ignored, with no effect on the operation.
- hi/lo/flags hold their last completed values until the next completion. They are never altered mid-operation.
- MUL (signed): 2*DATA_W two's-complement product {hi,lo}. MULU: unsigned product. ovf=0 and div_zero=0.
- DIV signed: quotient truncated toward zero. Remainder takes the dividend's sign. Signed sign-correction is applied on the DONE transition.
- DIV by zero (b=0, either DIV op): skips RUN and goes directly IDLE/DONE to DONE, so done appears 1 cycle after start. lo = all ones, hi = a, div_zero=1, ovf=0.
- Signed DIV with a=MIN (1 followed by zeros) and b=all ones: runs normally, then forces lo=MIN, hi=0, ovf=1.
- Flags are cleared on every normal completion.
- flush=1 (synchronous): next state is IDLE and busy drops. No done is produced; hi/lo/flags are unchanged. flush wins over a simultaneous start. flush in IDLE has no effect.
- reset asserted mid-operation: immediate return to reset values. No done is produced.
- Counter never wraps. Counter and internal accumulators are 2*DATA_W+1 bits wide where needed; no truncation before the final result.

Test Plan:
- MUL signed, a=0x0007, b=0xFFFD, start at edge k: busy high 16 cycles; done at k+17; hi=0xFFFF, lo=0xFFEB, flags 0.
- MULU, a=0xFFFF, b=0xFFFF: hi=0xFFFE, lo=0x0001. Immediately restart with DIVU 100/7 during DONE: second done 17 cycles later, lo=0x000E, hi=0x0002.
- DIV signed, a=0xFFF9 (-7), b=0x0002: lo=0xFFFD, hi=0xFFFF. Then a=0x8000, b=0xFFFF: lo=0x8000, hi=0x0000, ovf=1.
- DIVU, a=0x0064, b=0x0000: busy never asserts; done the cycle after start; lo=0xFFFF, hi=0x0064, div_zero=1.
- Start MUL, assert flush at busy cycle 5, plus a simultaneous flush+start: busy falls next cycle; no done; hi/lo retain previous values; unit returns to IDLE.
- Drive reset=0 mid-RUN: busy, done, hi, lo, and flags are 0 asynchronously. After release, a new MULU 3*5 gives lo=0x000F.
- Repeat the first and third scenarios with DATA_W=8 and DATA_W=32: latency is DATA_W+1 and results are correct at width.
